// File: rtl/mem_stage.sv
// Memory-access stage of the minimum MIPS core: forwards ALU results to write-back,
// runs LW/SW over a req/ack data-memory handshake with a timeout watchdog.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  input  logic [31:0] nextPC,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        WBValid,
  output logic [31:0] WBData,
  output logic [4:0]  WBReg,
  output logic        WBWe,
  output logic        AdrErr,
  output logic        BusErr
);

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             is_load;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_op;
  logic       accept;
  logic       misaligned;
  logic       pass_through;
  logic       timeout;
  logic       r_form_writes;
  logic       unused_ins_bits;

  assign opcode          = Ins[31:26];
  assign funct           = Ins[5:0];
  assign unused_ins_bits = ^{Ins[25:21], Ins[10:6]};
  assign Stall           = (state == ACCESS);

  // Handshake: mem_req rises at the accept edge and its companion address/data/we
  // stay frozen until the cycle mem_ack=1 is sampled (or the watchdog fires).
  always_comb begin
    mem_op        = (opcode == OP_LW) || (opcode == OP_SW);
    accept        = (state == IDLE) && Valid && mem_op && (Result[1:0] == 2'b00);
    misaligned    = (state == IDLE) && Valid && mem_op && (Result[1:0] != 2'b00);
    pass_through  = (state == IDLE) && Valid && !mem_op;
    timeout       = (state == ACCESS) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));
    r_form_writes = !(funct == 6'h08 || funct == 6'h11 || funct == 6'h13 ||
                      (funct >= 6'h18 && funct <= 6'h1B));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  if (mem_ack || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      is_load   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      WBValid   <= 1'b0;
      WBData    <= '0;
      WBReg     <= '0;
      WBWe      <= 1'b0;
      AdrErr    <= 1'b0;
      BusErr    <= 1'b0;
    end else begin
      WBValid <= 1'b0;
      AdrErr  <= 1'b0;
      BusErr  <= 1'b0;

      if (pass_through) begin
        WBValid <= 1'b1;
        if (opcode == OP_R_FORM) begin
          WBData <= Result;
          WBReg  <= Ins[15:11];
          WBWe   <= r_form_writes;
        end else if (opcode >= 6'h08 && opcode <= 6'h0F) begin
          WBData <= Result;
          WBReg  <= Ins[20:16];
          WBWe   <= 1'b1;
        end else if (opcode == OP_JAL) begin
          WBData <= nextPC;
          WBReg  <= 5'd31;
          WBWe   <= 1'b1;
        end else begin
          WBData <= Result;
          WBReg  <= 5'd0;
          WBWe   <= 1'b0;
        end
      end

      if (misaligned) begin
        WBValid <= 1'b1;
        AdrErr  <= 1'b1;
        WBData  <= '0;
        WBReg   <= Ins[20:16];
        WBWe    <= 1'b0;
      end

      if (accept) begin
        mem_req   <= 1'b1;
        mem_we    <= (opcode == OP_SW);
        mem_addr  <= Result;
        mem_wdata <= (opcode == OP_SW) ? Rdata2 : 32'h0;
        WBReg     <= Ins[20:16];
        is_load   <= (opcode == OP_LW);
        cnt       <= '0;
      end

      // Ack takes priority over the watchdog when both land in the same cycle.
      if (state == ACCESS) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          WBValid <= 1'b1;
          if (is_load) begin
            WBData <= mem_rdata;
            WBWe   <= 1'b1;
          end else begin
            WBWe   <= 1'b0;
          end
        end else if (timeout) begin
          mem_req <= 1'b0;
          BusErr  <= 1'b1;
          WBValid <= 1'b1;
          WBData  <= '0;
          WBWe    <= 1'b0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the minimum MIPS core. It sits directly downstream of EX and consumes EX's Result, the store data and the instruction word. LW/SW go to an external data memory over a req/ack handshake, with a timeout watchdog. It produces a registered write-back bundle (data, destination register, write enable) and a Stall signal back to upstream stages.

Parameters:
TIMEOUT, 16, max consecutive cycles mem_req may be held without mem_ack before abort (≥1)
CNT_W, 8, width of the watchdog counter (2^CNT_W > TIMEOUT)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
Valid  in  1  EX presents a valid instruction this cycle
Ins  in  32  instruction word
Result  in  32  EX Result: ALU result or LW/SW byte address
Rdata2  in  32  store data (rt)
nextPC  in  32  PC+4, link value for JAL
Stall  out  1  upstream must hold its outputs; high while state==ACCESS
mem_req  out  1  memory request
mem_we  out  1  1=store, 0=load
mem_addr  out  32  word-aligned byte address
mem_wdata  out  32  store data
mem_ack  in  1  memory completes request this cycle
mem_rdata  in  32  load data, valid when mem_ack=1
WBValid  out  1  one-cycle pulse, WB bundle valid
WBData  out  32  write-back value
WBReg  out  5  destination register
WBWe  out  1  register-file write enable (meaningful when WBValid=1)
AdrErr  out  1  one-cycle pulse, misaligned LW/SW
BusErr  out  1  one-cycle pulse, memory timeout

Behaviour:
- Opcodes: R_FORM=6'h00, JAL=6'h03, ADDI..XORI/LUI=6'h08–6'h0F, LW=6'h23, SW=6'h2B. All other opcodes are "other".
- Reset: state=IDLE, counter=0. All outputs are 0, including mem_* and WB*. Reset during ACCESS drops mem_req at that edge, and no WBValid is produced for the aborted access.
- FSM states: IDLE and ACCESS. Stall = (state==ACCESS), combinational from state only.
- IDLE, Valid=0: WBValid, AdrErr and BusErr are 0 next cycle. WBData, WBReg and WBWe hold.
- IDLE, Valid=1, non-memory op: next edge sets WBValid=1 (1-cycle latency) with the following bundle.
  - R_FORM: WBData=Result, WBReg=Ins[15:11]. WBWe=1 unless Funct ∈ {08 JR, 11 MTHI, 13 MTLO, 18–1B MULT/MULTU/DIV/DIVU}.
  - Opcodes 08–0F: WBData=Result, WBReg=Ins[20:16], WBWe=1.
  - JAL: WBData=nextPC, WBReg=31, WBWe=1.
  - Other opcodes: WBWe=0, WBData=Result, WBReg=0.
- IDLE, Valid=1, LW/SW, Result[1:0]!=0: no request is issued. Next edge pulses AdrErr=1 and WBValid=1, with WBWe=0, WBData=0. State stays IDLE.
- IDLE, Valid=1, LW/SW, aligned:
  - At the edge, latch mem_addr=Result, mem_we=(SW), mem_wdata=Rdata2 (0 for LW), WBReg=Ins[20:16]. Set mem_req=1, counter=0, state=ACCESS.
  - Upstream is not stalled in the accept cycle.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until completion. Valid is ignored.
  - mem_ack=1: next edge sets mem_req=0 and state=IDLE, and pulses WBValid=1. LW: WBData=mem_rdata, WBWe=1. SW: WBWe=0.
  - mem_ack=0: counter+1. If counter reaches TIMEOUT-1 in this cycle, the next edge aborts: mem_req=0, BusErr=1, WBValid=1, WBWe=0, WBData=0, state=IDLE.
  - mem_ack and timeout in the same cycle: ack wins.
- mem_ack while IDLE is ignored.
- Pulse outputs (WBValid, AdrErr, BusErr) are high for exactly one cycle per event. There are never two WB pulses for one instruction.
- Fastest load (ack in first ACCESS cycle): WBValid arrives 2 cycles after accept.
- An instruction held by Stall is accepted in the first IDLE cycle after completion, with exactly one WB pulse.

Test Plan:
- Reset then ADDU rd=5 (Ins=32'h00A42821), Result=32'h1234 → next cycle WBValid=1, WBData=32'h1234, WBReg=5, WBWe=1. Stall stays 0.
- LW rt=8, Result=32'h100, mem_ack returned in 3rd ACCESS cycle with rdata=32'hDEADBEEF → mem_req high 3 cycles with addr 32'h100 and we=0. Stall high 3 cycles. Then WBValid=1, WBData=32'hDEADBEEF, WBReg=8, WBWe=1.
- SW with Result=32'h104, Rdata2=32'hCAFEF00D; ADD presented during ACCESS → mem_we=1, wdata=32'hCAFEF00D held until ack. WBValid for SW has WBWe=0. ADD is accepted the cycle after Stall drops and gets its own single WB pulse.
- LW with Result=32'h102 → no mem_req. AdrErr=1 and WBValid=1 with WBWe=0 for one cycle.
- TIMEOUT=4, LW with no ack → mem_req high exactly 4 cycles, then BusErr=1 and WBValid=1 with WBWe=0. State returns to IDLE. Also ack on 4th cycle → normal completion, BusErr=0.
- Assert RST during 2nd ACCESS cycle → next cycle mem_req=0, Stall=0, and no WBValid, AdrErr or BusErr pulse. JAL after reset gives WBReg=31, WBData=nextPC.
